// File: rtl/vga_pkg.sv
// Shared types, latency arithmetic and elaboration helpers for the VGA
// layer compositor pixel path.
package vga_pkg;

  localparam int COORD_W             = 12;
  localparam int PIPE_OVERHEAD       = 2;   // address register + output register
  localparam int DEFAULT_MEM_LATENCY = 1;
  localparam int DEFAULT_PIXEL_WIDTH = 18;

  // Total cycles from raw timing inputs to registered outputs.
  function automatic int latency_of(input int mem_latency);
    return mem_latency + PIPE_OVERHEAD;
  endfunction

  localparam int LATENCY = latency_of(DEFAULT_MEM_LATENCY);

  typedef logic [DEFAULT_PIXEL_WIDTH-1:0] rgb_t;
  typedef logic [COORD_W-1:0]             coord_t;

  // Ceiling log2, used to check that the address splits into row/column fields.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Synchronous-reset shift register used to latency-match timing, image
// flags and overlay bits. DEPTH of zero is a plain wire.
module vga_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DEPTH == 0) begin : g_pass
    assign dout = din;
  end else begin : g_pipe
    logic [WIDTH-1:0] pipe_q [DEPTH];
    logic [WIDTH-1:0] pipe_d [DEPTH];

    // Next-state: every stage takes the one before it, stage 0 takes din.
    always_comb begin
      pipe_d[0] = din;
      for (int i = 1; i < DEPTH; i++) pipe_d[i] = pipe_q[i-1];
    end

    // Shift on every clock; reset flushes every stage to zero.
    always_ff @(posedge clk) begin
      if (reset) begin
        for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
      end else begin
        pipe_q <= pipe_d;
      end
    end

    assign dout = pipe_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_layer_compositor.sv
// Pixel path: scaled/offset framebuffer image with border fill, then
// priority-ordered 1-bit overlays, all outputs aligned to one latency.
// Framebuffer contract: fb_read_addr/fb_read_en are registered; the word for
// a strobed address is sampled exactly MEM_LATENCY cycles later, no stalls.
module vga_layer_compositor
  import vga_pkg::*;
#(
  parameter int PIXEL_WIDTH  = 18,
  parameter int IMG_W_BITS   = 8,
  parameter int IMG_HEIGHT   = 192,
  parameter int ADDR_WIDTH   = 16,
  parameter int MEM_LATENCY  = 1,
  parameter int NUM_OVERLAYS = 2,
  parameter int OVERLAY_LAT  = 1
) (
  input  logic                                clk_pixel,
  input  logic                                reset,
  input  logic [11:0]                         vga_x,
  input  logic [11:0]                         vga_y,
  input  logic                                video_active,
  input  logic                                vga_hsync,
  input  logic                                vga_vsync,
  input  logic [1:0]                          cfg_scale_shift,
  input  logic [11:0]                         cfg_offset_x,
  input  logic [11:0]                         cfg_offset_y,
  input  logic [PIXEL_WIDTH-1:0]              cfg_border_color,
  input  logic [NUM_OVERLAYS-1:0]             cfg_overlay_en,
  input  logic [NUM_OVERLAYS-1:0]             overlay_set,
  input  logic [NUM_OVERLAYS*PIXEL_WIDTH-1:0] overlay_color,
  output logic                                fb_read_en,
  output logic [ADDR_WIDTH-1:0]               fb_read_addr,
  input  logic [PIXEL_WIDTH-1:0]              fb_read_data,
  output logic [PIXEL_WIDTH/3-1:0]            VGA_R,
  output logic [PIXEL_WIDTH/3-1:0]            VGA_G,
  output logic [PIXEL_WIDTH/3-1:0]            VGA_B,
  output logic                                VGA_HSYNC,
  output logic                                VGA_VSYNC,
  output logic                                VGA_ACTIVE
);

  localparam int          CH_W     = PIXEL_WIDTH / 3;
  localparam int          ROW_W    = ADDR_WIDTH - IMG_W_BITS;
  localparam int          LAT      = latency_of(MEM_LATENCY);
  localparam int          OV_DELAY = MEM_LATENCY + 1 - OVERLAY_LAT;
  localparam logic [11:0] IMG_H    = 12'(IMG_HEIGHT);

  if (ADDR_WIDTH != IMG_W_BITS + clog2(IMG_HEIGHT) || (PIXEL_WIDTH % 3) != 0) begin : g_bad_params
    $error("vga_layer_compositor: ADDR_WIDTH or PIXEL_WIDTH inconsistent with image geometry");
  end

  // Shadow configuration, reloaded only at the first pixel of a frame.
  logic [1:0]              scale_q, scale_d;
  coord_t                  off_x_q, off_x_d;
  coord_t                  off_y_q, off_y_d;
  logic [PIXEL_WIDTH-1:0]  border_q, border_d;
  logic [NUM_OVERLAYS-1:0] ov_en_q, ov_en_d;
  logic                    frame_start;

  assign frame_start = (vga_x == 12'd0) && (vga_y == 12'd0);

  // Capture cycle takes the live cfg so pixel (0,0) already sees the new frame setup.
  always_comb begin
    scale_d  = scale_q;
    off_x_d  = off_x_q;
    off_y_d  = off_y_q;
    border_d = border_q;
    ov_en_d  = ov_en_q;
    if (frame_start) begin
      scale_d  = cfg_scale_shift;
      off_x_d  = cfg_offset_x;
      off_y_d  = cfg_offset_y;
      border_d = cfg_border_color;
      ov_en_d  = cfg_overlay_en;
    end
  end

  // Shadow registers; reset loads them straight from the cfg inputs.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      scale_q  <= cfg_scale_shift;
      off_x_q  <= cfg_offset_x;
      off_y_q  <= cfg_offset_y;
      border_q <= cfg_border_color;
      ov_en_q  <= cfg_overlay_en;
    end else begin
      scale_q  <= scale_d;
      off_x_q  <= off_x_d;
      off_y_q  <= off_y_d;
      border_q <= border_d;
      ov_en_q  <= ov_en_d;
    end
  end

  // Stage A: image-relative coordinates, bounds test and framebuffer address.
  logic signed [12:0]    rel_x, rel_y;
  logic [11:0]           src_x, src_y;
  logic                  in_image;
  logic                  fb_read_en_q, fb_read_en_d;
  logic [ADDR_WIDTH-1:0] fb_read_addr_q, fb_read_addr_d;

  // Negative relative coordinates are rejected via the sign bit, never wrapped.
  always_comb begin
    rel_x          = $signed({1'b0, vga_x}) - $signed({1'b0, off_x_d});
    rel_y          = $signed({1'b0, vga_y}) - $signed({1'b0, off_y_d});
    src_x          = rel_x[11:0] >> scale_d;
    src_y          = rel_y[11:0] >> scale_d;
    in_image       = !rel_x[12] && !rel_y[12] &&
                     ((src_x >> IMG_W_BITS) == 12'd0) && (src_y < IMG_H);
    fb_read_en_d   = video_active && in_image;
    fb_read_addr_d = fb_read_en_d ? {src_y[ROW_W-1:0], src_x[IMG_W_BITS-1:0]}
                                  : fb_read_addr_q;
  end

  // Address register holds its last value between strobes.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      fb_read_en_q   <= 1'b0;
      fb_read_addr_q <= '0;
    end else begin
      fb_read_en_q   <= fb_read_en_d;
      fb_read_addr_q <= fb_read_addr_d;
    end
  end

  assign fb_read_en   = fb_read_en_q;
  assign fb_read_addr = fb_read_addr_q;

  // Alignment lines: flags meet fb_read_data, timing meets the RGB register output.
  logic [1:0]              img_act_al;
  logic [2:0]              sync_al;
  logic [NUM_OVERLAYS-1:0] ov_set_al;

  vga_delay_line #(.WIDTH(2), .DEPTH(MEM_LATENCY + 1)) u_img_dly (
    .clk(clk_pixel), .reset(reset), .din({in_image, video_active}), .dout(img_act_al)
  );

  vga_delay_line #(.WIDTH(3), .DEPTH(LAT)) u_sync_dly (
    .clk(clk_pixel), .reset(reset), .din({video_active, vga_hsync, vga_vsync}), .dout(sync_al)
  );

  vga_delay_line #(.WIDTH(NUM_OVERLAYS), .DEPTH(OV_DELAY)) u_ov_dly (
    .clk(clk_pixel), .reset(reset), .din(overlay_set), .dout(ov_set_al)
  );

  // Output stage: blank, else lowest enabled+set overlay, else image, else border.
  logic [PIXEL_WIDTH-1:0] rgb_q, rgb_d;

  // Overlay loop runs high-to-low so the lowest index is the last writer and wins.
  always_comb begin
    rgb_d = '0;
    if (img_act_al[0]) begin
      rgb_d = img_act_al[1] ? fb_read_data : border_q;
      for (int i = NUM_OVERLAYS - 1; i >= 0; i--) begin
        if (ov_en_q[i] && ov_set_al[i]) rgb_d = overlay_color[i*PIXEL_WIDTH +: PIXEL_WIDTH];
      end
    end
  end

  // Registered colour output.
  always_ff @(posedge clk_pixel) begin
    if (reset) rgb_q <= '0;
    else       rgb_q <= rgb_d;
  end

  assign VGA_R      = rgb_q[PIXEL_WIDTH-1 -: CH_W];
  assign VGA_G      = rgb_q[PIXEL_WIDTH-CH_W-1 -: CH_W];
  assign VGA_B      = rgb_q[CH_W-1:0];
  assign VGA_ACTIVE = sync_al[2];
  assign VGA_HSYNC  = sync_al[1];
  assign VGA_VSYNC  = sync_al[0];

endmodule

// File: tb/tb_vga_layer_compositor.sv
// Bench for vga_layer_compositor: directed scenarios plus randomized frames,
// each pixel's expected output computed from screen-to-image arithmetic.
module tb_vga_layer_compositor;

  localparam int PW  = 18;
  localparam int LAT = 3;   // MEM_LATENCY (1) + 2

  typedef struct packed {
    logic [11:0] x;
    logic [11:0] y;
    logic        act;
    logic        hs;
    logic        vs;
    logic [1:0]  ov;
  } px_t;

  // Clock/reset and DUT connections
  logic           clk_pixel = 1'b0;
  logic           reset;
  logic [11:0]    vga_x, vga_y;
  logic           video_active, vga_hsync, vga_vsync;
  logic [1:0]     cfg_scale_shift;
  logic [11:0]    cfg_offset_x, cfg_offset_y;
  logic [PW-1:0]  cfg_border_color;
  logic [1:0]     cfg_overlay_en;
  logic [1:0]     overlay_set;
  logic [2*PW-1:0] overlay_color;
  logic           fb_read_en;
  logic [15:0]    fb_read_addr;
  logic [PW-1:0]  fb_read_data;
  logic [5:0]     VGA_R, VGA_G, VGA_B;
  logic           VGA_HSYNC, VGA_VSYNC, VGA_ACTIVE;

  always #5 clk_pixel = ~clk_pixel;

  vga_layer_compositor dut (
    .clk_pixel(clk_pixel), .reset(reset),
    .vga_x(vga_x), .vga_y(vga_y), .video_active(video_active),
    .vga_hsync(vga_hsync), .vga_vsync(vga_vsync),
    .cfg_scale_shift(cfg_scale_shift), .cfg_offset_x(cfg_offset_x),
    .cfg_offset_y(cfg_offset_y), .cfg_border_color(cfg_border_color),
    .cfg_overlay_en(cfg_overlay_en), .overlay_set(overlay_set),
    .overlay_color(overlay_color),
    .fb_read_en(fb_read_en), .fb_read_addr(fb_read_addr), .fb_read_data(fb_read_data),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .VGA_HSYNC(VGA_HSYNC), .VGA_VSYNC(VGA_VSYNC), .VGA_ACTIVE(VGA_ACTIVE)
  );

  // Framebuffer contents are a fixed hash of the address.
  function automatic logic [PW-1:0] fb_word(input logic [15:0] a);
    logic [31:0] h;
    h = {16'h0, a} * 32'd40503 + 32'h0001_2345;
    return h[PW-1:0] ^ {2'b00, a};
  endfunction

  // One-cycle-latency framebuffer responder
  always @(posedge clk_pixel) begin
    if (fb_read_en) fb_read_data <= fb_word(fb_read_addr);
  end

  // Reference model state and scoreboard
  int            m_shift, m_offx, m_offy;
  logic [PW-1:0] m_border;
  logic [1:0]    m_en;
  logic [15:0]   m_addr;
  logic [1:0]    prev_ov;
  logic [20:0]   exp_q[$];
  int            n_cmp = 0;
  int            n_bad = 0;

  function automatic px_t px(input int x, input int y, input bit act, input bit hs,
                             input bit vs, input logic [1:0] ov);
    px_t p;
    p.x = 12'(x); p.y = 12'(y); p.act = act; p.hs = hs; p.vs = vs; p.ov = ov;
    return p;
  endfunction

  function automatic px_t fill();
    return px(900, 500, 1'b0, 1'b0, 1'b0, 2'b00);
  endfunction

  task automatic load_model_cfg();
    m_shift  = int'(cfg_scale_shift);
    m_offx   = int'(cfg_offset_x);
    m_offy   = int'(cfg_offset_y);
    m_border = cfg_border_color;
    m_en     = cfg_overlay_en;
  endtask

  // Driver: one pixel per clock; overlay bits for a pixel go out one cycle later.
  task automatic step(input px_t p, output logic have, output logic [20:0] got,
                      output logic [20:0] want, output logic [16:0] got_fb,
                      output logic [16:0] want_fb);
    int rx, ry, sx, sy, hit;
    logic inimg, en;
    logic [15:0] a;
    logic [PW-1:0] rgb;
    @(negedge clk_pixel);
    reset = 1'b0;
    vga_x = p.x; vga_y = p.y;
    video_active = p.act; vga_hsync = p.hs; vga_vsync = p.vs;
    overlay_set = prev_ov;
    prev_ov = p.ov;
    if (p.x == 12'd0 && p.y == 12'd0) load_model_cfg();
    rx = int'(p.x) - m_offx;
    ry = int'(p.y) - m_offy;
    sx = (rx >= 0) ? (rx >> m_shift) : -1;
    sy = (ry >= 0) ? (ry >> m_shift) : -1;
    inimg = (sx >= 0) && (sy >= 0) && (sx < 256) && (sy < 192);
    a = inimg ? 16'(sy * 256 + sx) : 16'h0;
    en = p.act && inimg;
    if (en) m_addr = a;
    rgb = '0;
    if (p.act) begin
      hit = -1;
      for (int i = 0; i < 2; i++) if (hit < 0 && m_en[i] && p.ov[i]) hit = i;
      if (hit >= 0)   rgb = overlay_color[hit*PW +: PW];
      else if (inimg) rgb = fb_word(a);
      else            rgb = m_border;
    end
    exp_q.push_back({p.act, p.hs, p.vs, rgb});
    @(posedge clk_pixel); #1;
    got     = {VGA_ACTIVE, VGA_HSYNC, VGA_VSYNC, VGA_R, VGA_G, VGA_B};
    got_fb  = {fb_read_en, fb_read_addr};
    want_fb = {en, m_addr};
    have    = 1'b0;
    want    = '0;
    if (exp_q.size() >= LAT) begin
      want = exp_q.pop_front();
      have = 1'b1;
    end
  endtask

  // Driver: one reset cycle while presenting pixel p; model resyncs to black fill.
  task automatic do_reset(input px_t p);
    @(negedge clk_pixel);
    reset = 1'b1;
    vga_x = p.x; vga_y = p.y;
    video_active = p.act; vga_hsync = p.hs; vga_vsync = p.vs;
    overlay_set = p.ov;
    load_model_cfg();
    prev_ov = 2'b00;
    @(posedge clk_pixel); #1;
    exp_q.delete();
    for (int i = 0; i < LAT - 1; i++) exp_q.push_back('0);
    m_addr = '0;
  endtask

  task automatic test_reset();
    px_t tbl [4];
    logic have; logic [20:0] got, want; logic [16:0] gfb, wfb;
    cfg_scale_shift = 2'd2; cfg_offset_x = 12'd0; cfg_offset_y = 12'd0;
    cfg_border_color = 18'h3F000; cfg_overlay_en = 2'b11;
    overlay_color = {18'h3FFFF, 18'h00FC0};
    do_reset(px(3, 3, 1'b1, 1'b1, 1'b1, 2'b00));
    n_cmp++;
    if ({VGA_ACTIVE, VGA_HSYNC, VGA_VSYNC, VGA_R, VGA_G, VGA_B, fb_read_en, fb_read_addr} !== 38'h0) begin
      n_bad++;
      $display("FAIL reset_state: got act=%b hs=%b vs=%b rgb=%h en=%b addr=%h, want all 0",
               VGA_ACTIVE, VGA_HSYNC, VGA_VSYNC, {VGA_R, VGA_G, VGA_B}, fb_read_en, fb_read_addr);
    end
    tbl = '{px(8, 8, 1'b1, 1'b1, 1'b1, 2'b00), px(9, 8, 1'b1, 1'b1, 1'b0, 2'b00),
            px(10, 8, 1'b1, 1'b0, 1'b1, 2'b00), fill()};
    for (int i = 0; i < 4; i++) begin
      step(tbl[i], have, got, want, gfb, wfb);
      n_cmp++;
      if (gfb !== wfb) begin n_bad++; $display("FAIL reset_fb[%0d]: got %h want %h", i, gfb, wfb); end
      if (have) begin
        n_cmp++;
        if (got !== want) begin n_bad++; $display("FAIL reset_out[%0d]: got %h want %h", i, got, want); end
      end
      if (i < 2) begin
        n_cmp++;
        if (got !== 21'h0) begin n_bad++; $display("FAIL reset_black[%0d]: got %h want 0", i, got); end
      end
    end
  endtask

  task automatic test_fb_addr();
    px_t tbl [3];
    logic have; logic [20:0] got, want; logic [16:0] gfb, wfb;
    tbl = '{px(5, 9, 1'b1, 1'b0, 1'b0, 2'b00), fill(), fill()};
    for (int i = 0; i < 3; i++) begin
      step(tbl[i], have, got, want, gfb, wfb);
      n_cmp++;
      if (gfb !== wfb) begin n_bad++; $display("FAIL fb_addr_fb[%0d]: got %h want %h", i, gfb, wfb); end
      if (have) begin
        n_cmp++;
        if (got !== want) begin n_bad++; $display("FAIL fb_addr_out[%0d]: got %h want %h", i, got, want); end
      end
      if (i == 0) begin
        n_cmp++;
        if (gfb !== 17'h10201) begin n_bad++; $display("FAIL fb_addr_0201: got %h want 10201", gfb); end
      end
      if (i == 2) begin
        n_cmp++;
        if (got !== {3'b100, fb_word(16'h0201)}) begin
          n_bad++; $display("FAIL fb_addr_rgb: got %h want %h", got, {3'b100, fb_word(16'h0201)});
        end
      end
    end
  endtask

  task automatic test_edge_columns();
    px_t tbl [4];
    logic have; logic [20:0] got, want; logic [16:0] gfb, wfb;
    tbl = '{px(1024, 0, 1'b1, 1'b0, 1'b0, 2'b00), px(1023, 0, 1'b1, 1'b0, 1'b0, 2'b00),
            fill(), fill()};
    for (int i = 0; i < 4; i++) begin
      step(tbl[i], have, got, want, gfb, wfb);
      n_cmp++;
      if (gfb !== wfb) begin n_bad++; $display("FAIL edge_fb[%0d]: got %h want %h", i, gfb, wfb); end
      if (have) begin
        n_cmp++;
        if (got !== want) begin n_bad++; $display("FAIL edge_out[%0d]: got %h want %h", i, got, want); end
      end
      if (i == 0) begin
        n_cmp++;
        if (gfb[16] !== 1'b0) begin n_bad++; $display("FAIL edge_x1024_en: got %b want 0", gfb[16]); end
      end
      if (i == 1) begin
        n_cmp++;
        if (gfb !== 17'h100FF) begin n_bad++; $display("FAIL edge_x1023_addr: got %h want 100ff", gfb); end
      end
      if (i == 2) begin
        n_cmp++;
        if (got !== {3'b100, 18'h3F000}) begin n_bad++; $display("FAIL edge_border: got %h want %h", got, {3'b100, 18'h3F000}); end
      end
    end
  endtask

  task automatic test_offsets();
    px_t tbl [7];
    logic have; logic [20:0] got, want; logic [16:0] gfb, wfb;
    cfg_offset_x = 12'd64; cfg_offset_y = 12'd32; cfg_scale_shift = 2'd0;
    tbl = '{fill(), fill(), px(0, 0, 1'b0, 1'b0, 1'b0, 2'b00),
            px(63, 40, 1'b1, 1'b0, 1'b0, 2'b00), px(64, 32, 1'b1, 1'b0, 1'b0, 2'b00),
            fill(), fill()};
    for (int i = 0; i < 7; i++) begin
      step(tbl[i], have, got, want, gfb, wfb);
      n_cmp++;
      if (gfb !== wfb) begin n_bad++; $display("FAIL offset_fb[%0d]: got %h want %h", i, gfb, wfb); end
      if (have) begin
        n_cmp++;
        if (got !== want) begin n_bad++; $display("FAIL offset_out[%0d]: got %h want %h", i, got, want); end
      end
      if (i == 4) begin
        n_cmp++;
        if (gfb !== 17'h10000) begin n_bad++; $display("FAIL offset_origin_addr: got %h want 10000", gfb); end
      end
      if (i == 5) begin
        n_cmp++;
        if (got !== {3'b100, 18'h3F000}) begin n_bad++; $display("FAIL offset_left_border: got %h want %h", got, {3'b100, 18'h3F000}); end
      end
    end
  endtask

  task automatic test_overlays();
    px_t tbl [8];
    logic have; logic [20:0] got, want; logic [16:0] gfb, wfb;
    tbl = '{px(100, 40, 1'b1, 1'b0, 1'b0, 2'b11), fill(), fill(),
            px(0, 0, 1'b0, 1'b0, 1'b0, 2'b00), px(100, 40, 1'b1, 1'b0, 1'b0, 2'b11),
            px(100, 40, 1'b0, 1'b0, 1'b0, 2'b11), fill(), fill()};
    for (int i = 0; i < 8; i++) begin
      if (i == 1) cfg_overlay_en = 2'b10;
      step(tbl[i], have, got, want, gfb, wfb);
      n_cmp++;
      if (gfb !== wfb) begin n_bad++; $display("FAIL overlay_fb[%0d]: got %h want %h", i, gfb, wfb); end
      if (have) begin
        n_cmp++;
        if (got !== want) begin n_bad++; $display("FAIL overlay_out[%0d]: got %h want %h", i, got, want); end
      end
      if (i == 2) begin
        n_cmp++;
        if (got[17:0] !== 18'h00FC0) begin n_bad++; $display("FAIL overlay_prio: got %h want 00fc0", got[17:0]); end
      end
      if (i == 6) begin
        n_cmp++;
        if (got[17:0] !== 18'h3FFFF) begin n_bad++; $display("FAIL overlay_disable0: got %h want 3ffff", got[17:0]); end
      end
      if (i == 7) begin
        n_cmp++;
        if (got !== 21'h0) begin n_bad++; $display("FAIL overlay_inactive: got %h want 0", got); end
      end
    end
  endtask

  task automatic test_shadow_cfg();
    px_t tbl [12];
    logic have; logic [20:0] got, want; logic [16:0] gfb, wfb;
    cfg_scale_shift = 2'd0; cfg_offset_x = 12'd0; cfg_offset_y = 12'd0; cfg_overlay_en = 2'b11;
    tbl = '{fill(), fill(), px(0, 0, 1'b0, 1'b0, 1'b0, 2'b00),
            px(20, 100, 1'b1, 1'b0, 1'b0, 2'b00), px(20, 100, 1'b1, 1'b0, 1'b0, 2'b00),
            px(21, 101, 1'b1, 1'b0, 1'b0, 2'b00), fill(), fill(),
            px(0, 0, 1'b0, 1'b0, 1'b0, 2'b00), px(20, 100, 1'b1, 1'b0, 1'b0, 2'b00),
            fill(), fill()};
    for (int i = 0; i < 12; i++) begin
      if (i == 4) cfg_offset_x = 12'd8;
      step(tbl[i], have, got, want, gfb, wfb);
      n_cmp++;
      if (gfb !== wfb) begin n_bad++; $display("FAIL shadow_fb[%0d]: got %h want %h", i, gfb, wfb); end
      if (have) begin
        n_cmp++;
        if (got !== want) begin n_bad++; $display("FAIL shadow_out[%0d]: got %h want %h", i, got, want); end
      end
      if (i == 4) begin
        n_cmp++;
        if (gfb !== 17'h16414) begin n_bad++; $display("FAIL shadow_midframe_addr: got %h want 16414", gfb); end
      end
      if (i == 9) begin
        n_cmp++;
        if (gfb !== 17'h1640C) begin n_bad++; $display("FAIL shadow_nextframe_addr: got %h want 1640c", gfb); end
      end
    end
  endtask

  task automatic test_reset_midline();
    px_t tbl [4];
    logic have; logic [20:0] got, want; logic [16:0] gfb, wfb;
    for (int i = 0; i < 2; i++) step(px(10 + i, 10, 1'b1, 1'b1, 1'b0, 2'b01), have, got, want, gfb, wfb);
    do_reset(px(12, 10, 1'b1, 1'b1, 1'b0, 2'b01));
    n_cmp++;
    if ({VGA_ACTIVE, VGA_HSYNC, VGA_VSYNC, VGA_R, VGA_G, VGA_B, fb_read_en} !== 22'h0) begin
      n_bad++;
      $display("FAIL midline_reset_state: got out=%h en=%b want 0",
               {VGA_ACTIVE, VGA_HSYNC, VGA_VSYNC, VGA_R, VGA_G, VGA_B}, fb_read_en);
    end
    tbl = '{px(13, 10, 1'b1, 1'b1, 1'b0, 2'b00), px(14, 10, 1'b1, 1'b1, 1'b0, 2'b00),
            px(15, 10, 1'b1, 1'b1, 1'b0, 2'b00), fill()};
    for (int i = 0; i < 4; i++) begin
      step(tbl[i], have, got, want, gfb, wfb);
      n_cmp++;
      if (gfb !== wfb) begin n_bad++; $display("FAIL midline_fb[%0d]: got %h want %h", i, gfb, wfb); end
      if (have) begin
        n_cmp++;
        if (got !== want) begin n_bad++; $display("FAIL midline_out[%0d]: got %h want %h", i, got, want); end
      end
      if (i == 2) begin
        n_cmp++;
        if (got[20:19] !== 2'b11) begin n_bad++; $display("FAIL midline_sync_resume: got %b want 11", got[20:19]); end
      end
    end
  endtask

  task automatic test_random();
    logic have; logic [20:0] got, want; logic [16:0] gfb, wfb;
    px_t p;
    for (int f = 0; f < 8; f++) begin
      cfg_scale_shift  = 2'($urandom_range(0, 3));
      cfg_offset_x     = 12'($urandom_range(0, 400));
      cfg_offset_y     = 12'($urandom_range(0, 300));
      cfg_border_color = 18'($urandom);
      cfg_overlay_en   = 2'($urandom_range(0, 3));
      for (int i = 0; i < 63; i++) begin
        if (i < 2)       p = fill();
        else if (i == 2) p = px(0, 0, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 2'($urandom_range(0, 3)));
        else if (i < 61) p = px($urandom_range(0, 1100), $urandom_range(1, 400),
                                ($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
                                2'($urandom_range(0, 3)));
        else             p = fill();
        if (i > 2 && i < 61 && $urandom_range(0, 19) == 0) begin
          cfg_offset_x     = 12'($urandom_range(0, 400));
          cfg_border_color = 18'($urandom);
          cfg_overlay_en   = 2'($urandom_range(0, 3));
        end
        step(p, have, got, want, gfb, wfb);
        n_cmp++;
        if (gfb !== wfb) begin n_bad++; $display("FAIL random_fb[%0d.%0d]: got %h want %h", f, i, gfb, wfb); end
        if (have) begin
          n_cmp++;
          if (got !== want) begin n_bad++; $display("FAIL random_out[%0d.%0d]: got %h want %h", f, i, got, want); end
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    vga_x = '0; vga_y = '0; video_active = 1'b0; vga_hsync = 1'b0; vga_vsync = 1'b0;
    overlay_set = '0; prev_ov = '0; m_addr = '0;
    cfg_scale_shift = '0; cfg_offset_x = '0; cfg_offset_y = '0;
    cfg_border_color = '0; cfg_overlay_en = '0; overlay_color = '0;
    repeat (2) @(posedge clk_pixel);
    test_reset();
    test_fb_addr();
    test_edge_columns();
    test_offsets();
    test_overlays();
    test_shadow_cfg();
    test_reset_midline();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_layer_compositor.md
Name: vga_layer_compositor

Overview:
Parametrised successor to the fixed framebuffer-plus-console pixel path. It takes raw timing from vga_timing_controller_preset and produces registered RGB and sync outputs. It reads a scaled, offset framebuffer image with a runtime power-of-two scale and fills outside the image with a border colour. It then composites NUM_OVERLAYS priority-ordered 1-bit overlays (console font layers, cursors) on top. Every output is latency-matched, so sync, active and RGB leave aligned.

Parameters:
PIXEL_WIDTH, 18, framebuffer word / RGB width; split into three equal channels (must be divisible by 3)
IMG_W_BITS, 8, log2 of image width (image width = 2**IMG_W_BITS)
IMG_HEIGHT, 192, image height in source rows
ADDR_WIDTH, 16, framebuffer address width; must equal IMG_W_BITS + clog2(IMG_HEIGHT)
MEM_LATENCY, 1, cycles from fb_read_addr/fb_read_en to valid fb_read_data (1..4)
NUM_OVERLAYS, 2, number of overlay layers (1..8)
OVERLAY_LAT, 1, cycles overlay inputs lag the coordinates they belong to (0..MEM_LATENCY+1)

Ports:
clk_pixel  in  1  pixel clock
reset  in  1  synchronous, active-high
vga_x  in  12  current pixel column
vga_y  in  12  current pixel row
video_active  in  1  visible-area flag for vga_x/vga_y
vga_hsync  in  1  raw hsync
vga_vsync  in  1  raw vsync
cfg_scale_shift  in  2  image upscale = 2**shift
cfg_offset_x  in  12  screen column of image left edge
cfg_offset_y  in  12  screen row of image top edge
cfg_border_color  in  PIXEL_WIDTH  colour outside image
cfg_overlay_en  in  NUM_OVERLAYS  per-layer enable
overlay_set  in  NUM_OVERLAYS  per-layer pixel-on, OVERLAY_LAT cycles after its coordinate
overlay_color  in  NUM_OVERLAYS*PIXEL_WIDTH  layer i colour in bits [i*PIXEL_WIDTH +: PIXEL_WIDTH]
fb_read_en  out  1  framebuffer read strobe
fb_read_addr  out  ADDR_WIDTH  framebuffer address
fb_read_data  in  PIXEL_WIDTH  framebuffer word
VGA_R  out  PIXEL_WIDTH/3  red
VGA_G  out  PIXEL_WIDTH/3  green
VGA_B  out  PIXEL_WIDTH/3  blue
VGA_HSYNC  out  1  delayed hsync
VGA_VSYNC  out  1  delayed vsync
VGA_ACTIVE  out  1  delayed active

Behaviour:
- LATENCY = MEM_LATENCY + 2 cycles from (vga_x, vga_y, video_active, syncs) to the outputs. Syncs and active pass through an identical-length shift register.
- Shadow config: scale, offsets, border colour and overlay enables are captured into shadow registers only on the cycle where vga_x==0 && vga_y==0. Mid-frame cfg changes take effect on the next frame. Reset loads the shadows from the cfg inputs directly.
- Stage A (cycle 0→1):
  - rel_x = vga_x - off_x and rel_y = vga_y - off_y, computed in 13-bit signed arithmetic.
  - in_image = rel_x>=0 && rel_y>=0 && (rel_x>>shift) < 2**IMG_W_BITS && (rel_y>>shift) < IMG_HEIGHT.
  - fb_read_addr <= {rel_y>>shift, rel_x>>shift}, truncated to the field widths. This is a concatenation, not a multiply.
  - fb_read_en <= video_active && in_image. The address holds its last value when fb_read_en is 0.
- Stage B: in_image and active are carried for MEM_LATENCY cycles.
- Overlays: overlay_set is delayed by MEM_LATENCY+1-OVERLAY_LAT cycles to align with fb_read_data.
- Output stage (register):
  - If !active: RGB = 0.
  - Else if the lowest-index enabled and set layer i exists: overlay_color[i].
  - Else if in_image: fb_read_data.
  - Else: cfg_border_color (shadow).
  - RGB is split as {R,G,B} = PIXEL_WIDTH bits, MSB first.
- Reset:
  - RGB, VGA_ACTIVE and fb_read_en are 0; fb_read_addr is 0.
  - VGA_HSYNC and VGA_VSYNC are 0 and all delay lines are flushed to 0.
  - The first LATENCY cycles after reset deasserts output black, with active 0.
  - Reset mid-frame behaves identically, with no partial pixels.
- Boundaries:
  - Negative rel is treated as out of image, never wrapped.
  - The last image column/row, (rel>>shift) = 2**IMG_W_BITS-1 or IMG_HEIGHT-1, is in image.
  - When the shadow capture cycle coincides with a cfg change, the new value is taken.
  - All layers disabled means pure framebuffer/border.

Decomposition:
- Package vga_pkg holds:
  - localparam LATENCY function of MEM_LATENCY;
  - typedef rgb_t (PIXEL_WIDTH) and coord_t (12 bits);
  - function clog2 for the ADDR_WIDTH check (elaboration assertion).
- One sub-module, vga_delay_line #(WIDTH, DEPTH): a synchronous-reset shift register. It is used for syncs/active, in_image and overlay alignment.

Test Plan:
1. shift=2, offsets 0, pixel (x=5, y=9) active → fb_read_addr=0x0201 one cycle later, fb_read_en=1; the framebuffer word appears on RGB exactly 3 cycles (MEM_LATENCY=1) after the input.
2. shift=2, x=1024, y=0 → fb_read_en=0; RGB = border 0x3F000 at latency 3. Also x=1023 → in image, addr low byte 0xFF.
3. Offsets (64, 32), shift=0, pixel (63, 40) → border; pixel (64, 32) → addr 0x0000.
4. Overlay 0 and 1 both set, colours 0x00FC0 and 0x3FFFF, both enabled → 0x00FC0. Disable layer 0 → 0x3FFFF. video_active=0 → RGB 0 regardless.
5. Change cfg_offset_x mid-frame at y=100 → the output mapping is unchanged until the next x=0, y=0. After that, the address reflects the new offset.
6. Assert reset for 1 cycle mid-line with hsync=1 active → the next cycle outputs all 0. Syncs follow the inputs again after 3 cycles, with no stale pixels.
